// File: rtl/clk_meter.sv
// clk_meter: measures period and high time of a slow clock/strobe in sysclk cycles.
// Ports:
//   sysclk    - system clock, all logic on posedge
//   reset     - asynchronous active-low reset
//   clk_in    - measured clock, asynchronous to sysclk
//   start     - one-cycle request to begin a measurement
//   period    - sysclk cycles between two consecutive detected rising edges
//   high_time - cycles within that period where synchronised clk_in was 1
//   valid     - one-cycle pulse, period/high_time updated
//   busy      - high while armed or measuring
//   timeout   - one-cycle pulse, measurement aborted
// Optional build macro CLK_METER_CONT_EN: continuous back-to-back measurement,
// a second start while busy stops it.
module clk_meter #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 65535,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             start,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             busy,
    output logic             timeout
);
`ifdef CLK_METER_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif
    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_d, rise;
    logic [CNT_W-1:0]       cnt, hcnt;
    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign busy = state != IDLE;
    // cnt doubles as the ARM wait counter. In MEASURE it already includes the
    // current cycle, so on the closing rise it equals t1-t0 and hcnt covers
    // [t0,t1). Both stay <= TIMEOUT because reaching it aborts.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sync      <= '0;
            s_d       <= 1'b0;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], clk_in};
            s_d     <= s;
            valid   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= ARM;
                    cnt   <= '0;
                end
                ARM: if (CONT && start) begin
                    state <= IDLE;
                end else if (rise) begin
                    state <= MEASURE;
                    cnt   <= ONE;
                    hcnt  <= ONE;
                end else if (cnt == TMO1) begin
                    state   <= IDLE;
                    timeout <= 1'b1;
                end else begin
                    cnt <= cnt + ONE;
                end
                MEASURE: if (CONT && start) begin
                    state <= IDLE;
                end else if (rise) begin
                    period    <= cnt;
                    high_time <= hcnt;
                    valid     <= 1'b1;
                    state     <= CONT ? MEASURE : IDLE;
                    cnt       <= ONE;
                    hcnt      <= ONE;
                end else if (cnt == TMO) begin
                    state   <= IDLE;
                    timeout <= 1'b1;
                end else begin
                    cnt  <= cnt + ONE;
                    hcnt <= hcnt + CNT_W'(s);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clk_meter.sv
// tb_clk_meter: self-checking bench for clk_meter using square-wave stimulus.
module tb_clk_meter;
    localparam int W   = 16;
    localparam int TMO = 2000;
`ifdef CLK_METER_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif
    logic         sysclk = 1'b0;
    logic         reset  = 1'b0;
    logic         clk_in = 1'b0;
    logic         start  = 1'b0;
    logic [W-1:0] period, high_time;
    logic         valid, busy, timeout;
    int           tests = 0;
    int           fails = 0;
    int           hi = 1;
    int           lo = 1;
    bit           stuck = 1'b1;

    clk_meter #(.CNT_W(W), .TIMEOUT(TMO), .SYNC_STAGES(2)) dut (
        .sysclk(sysclk), .reset(reset), .clk_in(clk_in), .start(start),
        .period(period), .high_time(high_time), .valid(valid), .busy(busy),
        .timeout(timeout)
    );

    always #5 sysclk = ~sysclk;

    // Square wave: hi cycles high then lo cycles low, or held low when stuck.
    initial begin : gen
        int ph;
        ph = 0;
        forever begin
            @(negedge sysclk);
            if (stuck) clk_in = 1'b0;
            else begin
                clk_in = ph < hi;
                ph = (ph + 1 >= hi + lo) ? 0 : ph + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
    endtask

    // Expected: period = h+l, high_time = h, exactly one valid (single shot)
    // or one valid every h+l cycles (continuous).
    task automatic run_meas(input int h, input int l, input bit mid, input string tag);
        int p, nv, c;
        bit got;
        hi = h; lo = l; stuck = 1'b0; p = h + l;
        cyc(2 * p + 10);
        pulse_start;
        got = 1'b0;
        for (int n = 0; n < 3 * p + 20 && !got; n++) begin
            @(negedge sysclk);
            start = mid && n == p / 2;
            got = valid;
        end
        start = 1'b0;
        chk({tag, " valid"}, 32'(got), 1);
        chk({tag, " period"}, 32'(period), p);
        chk({tag, " high_time"}, 32'(high_time), h);
        chk({tag, " busy"}, 32'(busy), 32'(CONT));
        if (CONT) begin
            for (int k = 0; k < 2; k++) begin
                c = 0;
                do begin
                    @(negedge sysclk);
                    c++;
                end while (!valid && c <= p + 5);
                chk({tag, " cont interval"}, c, p);
                chk({tag, " cont period"}, 32'(period), p);
                chk({tag, " cont high_time"}, 32'(high_time), h);
            end
            pulse_start;
            chk({tag, " cont stop busy"}, 32'(busy), 0);
        end
        nv = 0;
        repeat (2 * p + 10) begin
            @(negedge sysclk);
            nv += int'(valid);
        end
        chk({tag, " no extra valid"}, nv, 0);
        chk({tag, " idle busy"}, 32'(busy), 0);
    endtask

    initial begin : main
        int k, nv;
        bit got, prev;
        cyc(3);
        chk("rst period", 32'(period), 0);
        chk("rst high_time", 32'(high_time), 0);
        chk("rst valid", 32'(valid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst timeout", 32'(timeout), 0);
        reset = 1'b1;
        cyc(5);

        run_meas(501, 501, 1'b0, "div500");
        run_meas(3, 7, 1'b0, "h3l7");

        // Stuck low: timeout TMO cycles after ARM entry, prior results kept.
        stuck = 1'b1;
        cyc(10);
        start = 1'b1;
        k = 0; got = 1'b0; nv = 0;
        while (k < TMO + 50 && !got) begin
            @(negedge sysclk);
            start = 1'b0;
            k++;
            got = timeout;
            nv += int'(valid);
        end
        chk("tmo seen", 32'(got), 1);
        chk("tmo latency", k, TMO + 1);
        chk("tmo no valid", nv, 0);
        chk("tmo period held", 32'(period), 10);
        chk("tmo high_time held", 32'(high_time), 3);
        chk("tmo busy", 32'(busy), 0);
        // start coinciding with the timeout pulse is accepted
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        chk("tmo pulse width", 32'(timeout), 0);
        chk("start on tmo busy", 32'(busy), 1);
        got = 1'b0;
        for (int n = 0; n < TMO + 10 && !got; n++) begin
            @(negedge sysclk);
            got = timeout;
        end
        chk("second tmo", 32'(got), 1);

`ifndef CLK_METER_CONT_EN
        run_meas(501, 501, 1'b1, "midstart");
`endif

        // Reset during MEASURE: outputs cleared at once, nothing afterwards.
        hi = 501; lo = 501; stuck = 1'b0;
        cyc(1100);
        pulse_start;
        prev = clk_in; got = 1'b0;
        for (int n = 0; n < 1100 && !got; n++) begin
            @(negedge sysclk);
            got = clk_in && !prev;
            prev = clk_in;
        end
        chk("rstmid edge seen", 32'(got), 1);
        cyc(300);
        chk("rstmid busy before", 32'(busy), 1);
        reset = 1'b0;
        #1;
        chk("rstmid period", 32'(period), 0);
        chk("rstmid high_time", 32'(high_time), 0);
        chk("rstmid busy", 32'(busy), 0);
        chk("rstmid valid", 32'(valid), 0);
        @(negedge sysclk);
        reset = 1'b1;
        nv = 0;
        repeat (3000) begin
            @(negedge sysclk);
            nv += int'(valid) + int'(timeout);
        end
        chk("rstmid no pulses", nv, 0);
        chk("rstmid idle", 32'(busy), 0);

        for (int i = 0; i < 6; i++)
            run_meas(int'($urandom_range(1, 60)), int'($urandom_range(1, 60)), 1'b0, "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
